load_store_unit: RTL and testbench

//  Sits between the CPU execute stage and DataMemory; the sole driver of DataMemory's

---
 rtl/load_store_unit_pkg.sv | 38 +++
 rtl/load_store_unit_byte_lane_align.sv | 40 ++++
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding and the request legality check.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_STATE_W = 2;

    typedef enum logic [LSU_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Unsigned stores do not exist in RV32I, so BU/HU are illegal for writes.
    function automatic logic req_is_err(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] lane,
                                        input logic       rmw_en);
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B:    err = write && !rmw_en;
            F3_H:    err = lane[0] || (write && !rmw_en);
            F3_W:    err = (lane != 2'b00);
            F3_BU:   err = write;
            F3_HU:   err = write || lane[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_store_unit_byte_lane_align.sv
// Little-endian lane handling: extracts/extends load data from a memory word and
// merges sub-word store data into a previously read word.
module load_store_unit_byte_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'h0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'h0, half_sel};
            default: ld_data = rdata;
        endcase

        st_data = rdata;
        case (funct3)
            F3_B: st_data[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1]) st_data[31:16] = wdata[15:0];
                else         st_data[15:0]  = wdata[15:0];
            end
            default: st_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and DataMemory: one request per
// handshake, sub-word stores via read-modify-write of the containing word.
//
// state   | meaning
// IDLE    | ready for a request
// RD      | DataMemory read, word captured into rdata_q
// WR      | DataMemory write of full or merged word
// RESP    | one-cycle response pulse
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter bit RMW_ENABLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [31:0]           dmem_addr,
    output logic [31:0]           dmem_din,
    output logic                  dmem_read,
    output logic                  dmem_write,
    input  logic [31:0]           dmem_dout
);

    lsu_state_e            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic                  write_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic                  load_done_q;
    logic                  ready_q;

    logic                  accept_err;
    logic [31:0]           word_addr;
    logic [31:0]           ld_data;
    logic [31:0]           st_data;

    assign accept_err = req_is_err(req_write, req_funct3, req_addr[1:0], RMW_ENABLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            load_done_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && ready_q) begin
                        addr_q      <= req_addr;
                        funct3_q    <= req_funct3;
                        write_q     <= req_write;
                        wdata_q     <= req_wdata;
                        err_q       <= accept_err;
                        load_done_q <= 1'b0;
                        ready_q     <= 1'b0;
                        if (accept_err)
                            state <= ST_RESP;
                        else if (req_write && req_funct3 == F3_W)
                            state <= ST_WR;
                        else
                            state <= ST_RD;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_RD: begin
                    rdata_q <= dmem_dout;
                    if (write_q) begin
                        state <= ST_WR;
                    end else begin
                        load_done_q <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_WR: state <= ST_RESP;
                ST_RESP: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    load_store_unit_byte_lane_align u_align (
        .rdata   (rdata_q),
        .wdata   (wdata_q),
        .lane    (addr_q[1:0]),
        .funct3  (funct3_q),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    always_comb begin
        word_addr = '0;
        word_addr[ADDR_WIDTH-1:2] = addr_q[ADDR_WIDTH-1:2];
    end

    // Memory strobes decode straight from state so reset drops them immediately.
    assign req_ready  = ready_q;
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = (state == ST_RESP) && err_q;
    assign resp_rdata = load_done_q ? ld_data : '0;
    assign dmem_read  = (state == ST_RD);
    assign dmem_write = (state == ST_WR);
    assign dmem_addr  = (state == ST_RD || state == ST_WR) ? word_addr : '0;
    assign dmem_din   = (state == ST_WR) ? st_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: bench-side DataMemory, queue-based reference model,
// directed scenarios plus randomized traffic, and an RMW-disabled instance.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, dmem_read, dmem_write;
    logic [31:0] resp_rdata, dmem_addr, dmem_din, dmem_dout;

    logic        u2_req_valid = 1'b0, u2_req_write = 1'b0;
    logic [2:0]  u2_req_funct3 = 3'b0;
    logic [31:0] u2_req_addr = 32'h0, u2_req_wdata = 32'h0;
    logic        u2_req_ready, u2_resp_valid, u2_resp_err, u2_dmem_read, u2_dmem_write;
    logic [31:0] u2_resp_rdata, u2_dmem_addr, u2_dmem_din, u2_dmem_dout;

    load_store_unit #(.ADDR_WIDTH(32), .RMW_ENABLE(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_dout(dmem_dout)
    );

    load_store_unit #(.ADDR_WIDTH(32), .RMW_ENABLE(1'b0)) dut_normw (
        .clk(clk), .reset(reset), .req_valid(u2_req_valid), .req_ready(u2_req_ready),
        .req_write(u2_req_write), .req_funct3(u2_req_funct3), .req_addr(u2_req_addr),
        .req_wdata(u2_req_wdata), .resp_valid(u2_resp_valid), .resp_rdata(u2_resp_rdata),
        .resp_err(u2_resp_err), .dmem_addr(u2_dmem_addr), .dmem_din(u2_dmem_din),
        .dmem_read(u2_dmem_read), .dmem_write(u2_dmem_write), .dmem_dout(u2_dmem_dout)
    );

    // DataMemory stand-ins: combinational read, write at rising edge.
    logic [31:0] dmem    [0:16383];
    logic [31:0] ref_mem [0:16383];
    logic [31:0] mem2    [0:15];
    assign dmem_dout    = dmem[dmem_addr[15:2]];
    assign u2_dmem_dout = mem2[u2_dmem_addr[5:2]];
    always @(posedge clk) if (dmem_write) dmem[dmem_addr[15:2]] <= dmem_din;
    always @(posedge clk) if (u2_dmem_write) mem2[u2_dmem_addr[5:2]] <= u2_dmem_din;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        int          acc_cyc;
        logic [31:0] waddr;
        logic [31:0] wdin;
        int          seen_rd;
        int          seen_wr;
    } exp_t;

    exp_t        q[$];
    exp_t        e_cur;
    int          cyc = 0;
    bit          model_on = 1'b1;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;
    int          last_resp_cyc = 0;

    // Reference model: expected outcome of one accepted request, from the
    // architectural rules only.
    task automatic model_push(input bit w, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] word, b, h, m, nw;
        int          sh, hs;
        bit          legal, err;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err = !legal || (w && (f3 == 3'd4 || f3 == 3'd5))
              || ((f3 == 3'd1 || f3 == 3'd5) && a[0])
              || (f3 == 3'd2 && a[1:0] != 2'b00);
        word = ref_mem[a[15:2]];
        sh = 8 * int'(a[1:0]);
        hs = 16 * int'(a[1]);
        b = (word >> sh) & 32'hFF;
        h = (word >> hs) & 32'hFFFF;
        e.rdata = 32'h0; e.err = err; e.acc_cyc = cyc;
        e.waddr = a & 32'hFFFF_FFFC; e.wdin = 32'h0;
        e.seen_rd = 0; e.seen_wr = 0;
        if (err) begin
            e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else if (!w) begin
            e.lat = 2; e.nrd = 1; e.nwr = 0;
            case (f3)
                3'd0: e.rdata = (b & 32'h80) != 0 ? (b | 32'hFFFF_FF00) : b;
                3'd1: e.rdata = (h & 32'h8000) != 0 ? (h | 32'hFFFF_0000) : h;
                3'd4: e.rdata = b;
                3'd5: e.rdata = h;
                default: e.rdata = word;
            endcase
        end else begin
            e.nwr = 1;
            if (f3 == 3'd2) begin
                e.nrd = 0; e.lat = 2; nw = wd;
            end else begin
                e.nrd = 1; e.lat = 3;
                if (f3 == 3'd0) m = 32'hFF << sh;
                else            m = 32'hFFFF << hs;
                nw = (word & ~m) | ((wd << (f3 == 3'd0 ? sh : hs)) & m);
            end
            ref_mem[a[15:2]] = nw;
            e.wdin = nw;
        end
        q.push_back(e);
    endtask

    // Single compare process: memory-side traffic and responses every cycle.
    always @(negedge clk) begin
        cyc++;
        if (model_on && reset) begin
            if (q.size() > 0) begin
                if (dmem_read) q[0].seen_rd = q[0].seen_rd + 1;
                if (dmem_write) begin
                    q[0].seen_wr = q[0].seen_wr + 1;
                    chk("dmem_din", dmem_din, q[0].wdin);
                end
                if (dmem_read || dmem_write) chk("dmem_addr", dmem_addr, q[0].waddr);
            end else if (dmem_read || dmem_write) begin
                chk("stray_access", {30'h0, dmem_read, dmem_write}, 32'h0);
            end
            if (!dmem_read && !dmem_write) chk("dmem_idle_zero", dmem_addr | dmem_din, 32'h0);
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'h1, 32'h0);
                end else begin
                    e_cur = q.pop_front();
                    chk("resp_rdata", resp_rdata, e_cur.rdata);
                    chk("resp_err", {31'h0, resp_err}, {31'h0, e_cur.err});
                    chk("latency", 32'(cyc - e_cur.acc_cyc), 32'(e_cur.lat));
                    chk("read_cycles", 32'(e_cur.seen_rd), 32'(e_cur.nrd));
                    chk("write_pulses", 32'(e_cur.seen_wr), 32'(e_cur.nwr));
                    last_rdata    = resp_rdata;
                    last_err      = resp_err;
                    last_resp_cyc = cyc;
                end
            end
        end
    end

    task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold, output int acc);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'h0, 32'h1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        model_push(w, f3, a, wd);
        acc = cyc;
        if (!hold) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("resp_timeout", 32'h0, 32'h1);
            q.delete();
        end
        @(negedge clk);
    endtask

    logic u2_err_cap;
    logic [31:0] u2_rdata_cap;
    int u2_acc = 0;
    always @(negedge clk) if (u2_dmem_read || u2_dmem_write) u2_acc++;

    task automatic u2_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        int n;
        @(negedge clk);
        u2_req_valid = 1'b1; u2_req_write = w; u2_req_funct3 = f3;
        u2_req_addr = a; u2_req_wdata = wd;
        n = 0;
        while (!u2_req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        u2_req_valid = 1'b0;
        n = 0;
        while (!u2_resp_valid && n < 10) begin @(negedge clk); n++; end
        if (!u2_resp_valid) chk("u2_resp_timeout", 32'h0, 32'h1);
        u2_err_cap   = u2_resp_err;
        u2_rdata_cap = u2_resp_rdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, n, sel;
        logic [2:0] f3;
        bit w, hold;
        logic [31:0] a;

        for (int i = 0; i < 16384; i++) begin dmem[i] = 32'h0; ref_mem[i] = 32'h0; end
        for (int i = 0; i < 16; i++) mem2[i] = 32'h0;
        dmem[16] = 32'h8899AABB; ref_mem[16] = 32'h8899AABB;
        dmem[18] = 32'h8899AABB; ref_mem[18] = 32'h8899AABB;
        mem2[0]  = 32'h8899AABB;

        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_dmem", dmem_addr | dmem_din | {30'h0, dmem_read, dmem_write}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

        // Byte loads with sign and zero extension
        issue(1'b0, 3'b000, 32'h41, 32'h0, 1'b0, acc); wait_idle();
        chk("lb_0x41", last_rdata, 32'hFFFFFFAA);
        chk("lb_lat", 32'(last_resp_cyc - acc), 32'd2);
        issue(1'b0, 3'b100, 32'h41, 32'h0, 1'b0, acc); wait_idle();
        chk("lbu_0x41", last_rdata, 32'h000000AA);

        // Sub-word store by read-modify-write
        issue(1'b1, 3'b000, 32'h42, 32'h11223344, 1'b0, acc); wait_idle();
        chk("sb_lat", 32'(last_resp_cyc - acc), 32'd3);
        chk("sb_mem_word", dmem[16], 32'h8844AABB);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, acc); wait_idle();
        chk("lw_after_sb", last_rdata, 32'h8844AABB);

        issue(1'b1, 3'b001, 32'h46, 32'h0000BEEF, 1'b0, acc); wait_idle();
        issue(1'b0, 3'b001, 32'h46, 32'h0, 1'b0, acc); wait_idle();
        chk("lh_0x46", last_rdata, 32'hFFFFBEEF);
        issue(1'b0, 3'b010, 32'h45, 32'h0, 1'b0, acc); wait_idle();
        chk("lw_misaligned_err", {31'h0, last_err}, 32'h1);
        chk("lw_misaligned_rdata", last_rdata, 32'h0);
        chk("lw_misaligned_lat", 32'(last_resp_cyc - acc), 32'd1);

        // Back-to-back with req_valid held
        issue(1'b1, 3'b010, 32'h80, 32'hCAFEF00D, 1'b1, acc);
        issue(1'b0, 3'b010, 32'h80, 32'h0, 1'b0, acc2);
        chk("b2b_accept_gap", 32'(acc2 - last_resp_cyc), 32'd1);
        wait_idle();
        chk("lw_0x80", last_rdata, 32'hCAFEF00D);

        // Randomized traffic over a small window
        for (int i = 256; i < 272; i++) begin
            dmem[i] = $urandom; ref_mem[i] = dmem[i];
        end
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1: f3 = 3'b000;
                2, 3: f3 = 3'b001;
                4, 5: f3 = 3'b010;
                6:    f3 = 3'b100;
                7:    f3 = 3'b101;
                8:    f3 = 3'b011;
                default: f3 = ($urandom_range(0, 1) != 0) ? 3'b110 : 3'b111;
            endcase
            w = ($urandom_range(0, 1) != 0);
            a = 32'h400 + 32'($urandom_range(0, 63));
            hold = (i != 199) && ($urandom_range(0, 1) != 0);
            issue(w, f3, a, $urandom, hold, acc);
        end
        wait_idle();
        for (int i = 256; i < 272; i++) chk("rand_mem", dmem[i], ref_mem[i]);

        // Reset during the write cycle of a byte store
        model_on = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h49; req_wdata = 32'h55;
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!dmem_write && n < 10) begin @(negedge clk); n++; end
        chk("abort_reached_wr", {31'h0, dmem_write}, 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("abort_dmem_write", {31'h0, dmem_write}, 32'h0);
        chk("abort_outputs", dmem_addr | dmem_din | resp_rdata |
            {28'h0, dmem_read, resp_valid, resp_err, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("abort_mem_unchanged", dmem[18], 32'h8899AABB);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
        model_on = 1'b1;
        issue(1'b0, 3'b010, 32'h48, 32'h0, 1'b0, acc); wait_idle();
        chk("abort_lw_after", last_rdata, 32'h8899AABB);

        // Instance without read-modify-write support
        u2_req(1'b1, 3'b000, 32'h40, 32'h11223344);
        chk("normw_sb_err", {31'h0, u2_err_cap}, 32'h1);
        chk("normw_sb_rdata", u2_rdata_cap, 32'h0);
        chk("normw_mem", mem2[0], 32'h8899AABB);
        chk("normw_no_access", 32'(u2_acc), 32'd0);
        u2_req(1'b0, 3'b011, 32'h40, 32'h0);
        chk("normw_f3_011_err", {31'h0, u2_err_cap}, 32'h1);
        u2_req(1'b1, 3'b010, 32'h44, 32'h12345678);
        chk("normw_sw_ok", {31'h0, u2_err_cap}, 32'h0);
        chk("normw_sw_mem", mem2[1], 32'h12345678);
        u2_req(1'b0, 3'b000, 32'h41, 32'h0);
        chk("normw_lb", u2_rdata_cap, 32'hFFFFFFAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
